// File: rtl/health_ctrl.sv
// health_ctrl: owns the lives count, the post-hit invulnerability window and the
// frame-aligned heart visibility mask consumed by the heart sprite renderers.
//
// state  | meaning
// ALIVE  | normal play; a hit costs a life
// INVULN | post-hit window; hits ignored, the lost heart blinks
// DEAD   | lives = 0; only RESTART or a non-zero SET leaves
module health_ctrl #(
  parameter int MAX_LIVES     = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_PERIOD  = 8
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 write_en0,
  input  logic                 right_addr,
  input  logic [31:0]          pwdata,
  input  logic                 animate,
  input  logic                 hit,
  input  logic                 heal,
  output logic [MAX_LIVES-1:0] hearts,
  output logic [3:0]           lives,
  output logic                 invuln,
  output logic                 game_over
);

  typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;

  localparam logic [1:0] OP_RESTART = 2'b01;
  localparam logic [1:0] OP_SET     = 2'b10;
  localparam logic [1:0] OP_KILL    = 2'b11;

  localparam logic [3:0] MAX_L      = 4'(MAX_LIVES);
  localparam logic [7:0] INV_F      = 8'(INVULN_FRAMES);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_PERIOD - 1);

  state_t               state_q;
  logic [3:0]           lives_q;
  logic [7:0]           inv_cnt;
  logic [7:0]           blink_cnt;
  logic                 blink_ph;
  logic [MAX_LIVES-1:0] hearts_q;
  logic [MAX_LIVES-1:0] mask_nxt;

  logic       cmd_valid;
  logic [1:0] op;
  logic [3:0] set_raw;
  logic [3:0] set_val;
  logic [3:0] lives_heal;
  logic       unused_pwdata;

  assign op            = pwdata[1:0];
  assign set_raw       = pwdata[11:8];
  assign set_val       = (set_raw > MAX_L) ? MAX_L : set_raw;
  assign cmd_valid     = write_en0 & right_addr & (op != 2'b00);
  assign lives_heal    = (lives_q < MAX_L) ? lives_q + 4'd1 : lives_q;
  assign unused_pwdata = ^{pwdata[31:12], pwdata[7:2]};

  // Mask is built from registered values only, so hearts shows the pre-edge view.
  always_comb begin
    mask_nxt = '0;
    for (int i = 0; i < MAX_LIVES; i++) begin
      if (i < int'(lives_q))
        mask_nxt[i] = 1'b1;
      else if (i == int'(lives_q) && state_q == INVULN && lives_q < MAX_L)
        mask_nxt[i] = blink_ph;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= ALIVE;
      lives_q   <= MAX_L;
      inv_cnt   <= 8'd0;
      blink_cnt <= 8'd0;
      blink_ph  <= 1'b1;
      hearts_q  <= '1;
    end else begin
      if (animate)
        hearts_q <= mask_nxt;

      if (cmd_valid) begin
        // Any real command aborts an invulnerability window in progress.
        inv_cnt   <= 8'd0;
        blink_cnt <= 8'd0;
        blink_ph  <= 1'b1;
        case (op)
          OP_RESTART: begin
            lives_q <= MAX_L;
            state_q <= ALIVE;
          end
          OP_SET: begin
            lives_q <= set_val;
            state_q <= (set_val == 4'd0) ? DEAD : ALIVE;
          end
          OP_KILL: begin
            lives_q <= 4'd0;
            state_q <= DEAD;
          end
          default: ;
        endcase
      end else begin
        case (state_q)
          ALIVE: begin
            if (hit) begin
              if (lives_q > 4'd1) begin
                lives_q   <= lives_q - 4'd1;
                inv_cnt   <= INV_F;
                blink_cnt <= 8'd0;
                blink_ph  <= 1'b1;
                state_q   <= INVULN;
              end else begin
                lives_q <= 4'd0;
                state_q <= DEAD;
              end
            end else if (heal) begin
              lives_q <= lives_heal;
            end
          end
          INVULN: begin
            if (heal)
              lives_q <= lives_heal;
            if (animate) begin
              if (inv_cnt <= 8'd1) begin
                inv_cnt <= 8'd0;
                state_q <= ALIVE;
              end else begin
                inv_cnt <= inv_cnt - 8'd1;
              end
              if (blink_cnt >= BLINK_LAST) begin
                blink_cnt <= 8'd0;
                blink_ph  <= ~blink_ph;
              end else begin
                blink_cnt <= blink_cnt + 8'd1;
              end
            end
          end
          DEAD: ;
          default: state_q <= ALIVE;
        endcase
      end
    end
  end

  assign hearts    = hearts_q;
  assign lives     = lives_q;
  assign invuln    = (state_q == INVULN);
  assign game_over = (state_q == DEAD);

endmodule

// File: tb/tb_health_ctrl.sv
// Scoreboard bench for health_ctrl: stimulus queues expected outputs, a monitor
// compares them on the falling edge following each stimulus step.
module tb_health_ctrl;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        write_en0 = 1'b0;
  logic        right_addr = 1'b0;
  logic [31:0] pwdata = 32'd0;
  logic        animate = 1'b0;
  logic        hit = 1'b0;
  logic        heal = 1'b0;
  logic [2:0]  hearts;
  logic [3:0]  lives;
  logic        invuln;
  logic        game_over;

  int compared = 0;
  int mismatched = 0;

  string      q_name[$];
  logic [8:0] q_exp[$];

  health_ctrl #(.MAX_LIVES(3), .INVULN_FRAMES(60), .BLINK_PERIOD(8)) dut (
    .clk(clk), .res(res), .write_en0(write_en0), .right_addr(right_addr),
    .pwdata(pwdata), .animate(animate), .hit(hit), .heal(heal),
    .hearts(hearts), .lives(lives), .invuln(invuln), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    animate = 1'b1;
    tick();
    animate = 1'b0;
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    tick();
    hit = 1'b0;
  endtask

  task automatic pulse_heal();
    heal = 1'b1;
    tick();
    heal = 1'b0;
  endtask

  task automatic apb(input logic [1:0] op, input logic [3:0] val);
    write_en0  = 1'b1;
    right_addr = 1'b1;
    pwdata     = {20'd0, val, 6'd0, op};
    tick();
    write_en0  = 1'b0;
    right_addr = 1'b0;
    pwdata     = 32'd0;
  endtask

  task automatic chk(input string name, input logic [2:0] h, input logic [3:0] l,
                     input logic i, input logic g);
    q_name.push_back(name);
    q_exp.push_back({h, l, i, g});
  endtask

  // Monitor: drains the scoreboard on every falling edge.
  initial begin
    logic [8:0] e;
    logic [8:0] act;
    string      n;
    forever begin
      @(negedge clk);
      while (q_exp.size() > 0) begin
        e   = q_exp.pop_front();
        n   = q_name.pop_front();
        act = {hearts, lives, invuln, game_over};
        compared++;
        if (act !== e) begin
          mismatched++;
          $display("FAIL %s: got hearts=%b lives=%0d invuln=%b game_over=%b, want hearts=%b lives=%0d invuln=%b game_over=%b",
                   n, act[8:6], act[5:2], act[1], act[0], e[8:6], e[5:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    mismatched++;
    $display("FAIL watchdog: got timeout, want stimulus complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    tick();
    tick();
    res = 1'b1;
    chk("reset", 3'b111, 4'd3, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      frame();
      chk("idle_frame", 3'b111, 4'd3, 1'b0, 1'b0);
    end

    // First hit between frames, then the full blink window.
    tick();
    pulse_hit();
    chk("hit_lives", 3'b111, 4'd2, 1'b1, 1'b0);
    for (int k = 1; k <= 60; k++) begin
      frame();
      chk("blink", ((((k - 1) / 8) % 2) == 0) ? 3'b111 : 3'b011, 4'd2, (k < 60), 1'b0);
      if (k == 20) begin
        pulse_hit();
        chk("hit_in_invuln", 3'b111, 4'd2, 1'b1, 1'b0);
      end
    end
    frame();
    chk("settled", 3'b011, 4'd2, 1'b0, 1'b0);

    // Second hit after the window ends.
    pulse_hit();
    chk("hit2_lives", 3'b011, 4'd1, 1'b1, 1'b0);
    for (int k = 1; k <= 60; k++) begin
      frame();
      if (k == 1) chk("inv2_first", 3'b011, 4'd1, 1'b1, 1'b0);
      if (k == 9) chk("inv2_blink_off", 3'b001, 4'd1, 1'b1, 1'b0);
      if (k == 60) chk("inv2_end", 3'b001, 4'd1, 1'b0, 1'b0);
    end

    // Fatal hit, then heal ignored while dead.
    pulse_hit();
    chk("fatal_hit", 3'b001, 4'd0, 1'b0, 1'b1);
    frame();
    chk("dead_hearts", 3'b000, 4'd0, 1'b0, 1'b1);
    pulse_heal();
    chk("heal_dead", 3'b000, 4'd0, 1'b0, 1'b1);

    apb(2'b01, 4'd0);
    chk("restart", 3'b000, 4'd3, 1'b0, 1'b0);
    frame();
    chk("restart_hearts", 3'b111, 4'd3, 1'b0, 1'b0);

    // Same-cycle priority.
    apb(2'b10, 4'd2);
    chk("set2", 3'b111, 4'd2, 1'b0, 1'b0);
    hit = 1'b1;
    heal = 1'b1;
    tick();
    hit = 1'b0;
    heal = 1'b0;
    chk("hit_over_heal", 3'b111, 4'd1, 1'b1, 1'b0);
    hit = 1'b1;
    apb(2'b10, 4'd9);
    hit = 1'b0;
    chk("set_clamp_over_hit", 3'b111, 4'd3, 1'b0, 1'b0);
    frame();
    chk("set_clamp_hearts", 3'b111, 4'd3, 1'b0, 1'b0);

    pulse_heal();
    chk("heal_saturate", 3'b111, 4'd3, 1'b0, 1'b0);
    apb(2'b11, 4'd0);
    chk("kill", 3'b111, 4'd0, 1'b0, 1'b1);
    frame();
    chk("kill_hearts", 3'b000, 4'd0, 1'b0, 1'b1);
    apb(2'b01, 4'd0);
    chk("restart2", 3'b000, 4'd3, 1'b0, 1'b0);
    frame();
    chk("restart2_hearts", 3'b111, 4'd3, 1'b0, 1'b0);
    apb(2'b10, 4'd0);
    chk("set_zero", 3'b111, 4'd0, 1'b0, 1'b1);
    apb(2'b01, 4'd0);
    chk("restart3", 3'b111, 4'd3, 1'b0, 1'b0);

    // Hit coincident with animate: window spans exactly 60 later animates.
    hit = 1'b1;
    animate = 1'b1;
    tick();
    hit = 1'b0;
    animate = 1'b0;
    chk("hit_on_frame", 3'b111, 4'd2, 1'b1, 1'b0);
    for (int k = 1; k <= 60; k++) begin
      frame();
      if (k == 59) chk("frame59", 3'b011, 4'd2, 1'b1, 1'b0);
      if (k == 60) chk("frame60", 3'b011, 4'd2, 1'b0, 1'b0);
    end

    // Asynchronous reset mid-window, asserted between clock edges.
    pulse_hit();
    chk("hit_before_reset", 3'b011, 4'd1, 1'b1, 1'b0);
    frame();
    frame();
    res = 1'b0;
    chk("async_reset", 3'b111, 4'd3, 1'b0, 1'b0);
    tick();
    chk("reset_held", 3'b111, 4'd3, 1'b0, 1'b0);
    res = 1'b1;
    frame();
    chk("post_reset_frame", 3'b111, 4'd3, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    if (q_exp.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
